// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Grants one op, registers the ALU result and returns it to the owner with a valid/ready handshake.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic [OP_W-1:0]   r0_op,
    output logic              r0_rsp_valid,
    input  logic              r0_rsp_ready,
    output logic [DATA_W-1:0] r0_rsp_data,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    input  logic [OP_W-1:0]   r1_op,
    output logic              r1_rsp_valid,
    input  logic              r1_rsp_ready,
    output logic [DATA_W-1:0] r1_rsp_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_c,
    input  logic [DATA_W-1:0] alu_y
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              last_grant_r;
    logic              owner_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic              grant_s;
    logic              winner_s;

    // Winner selection; grants are suppressed while reset is held
    always_comb begin
        grant_s  = 1'b0;
        winner_s = 1'b0;
        if (!rst && state_r == IDLE) begin
            grant_s = r0_valid | r1_valid;
            if (r0_valid && r1_valid) begin
                winner_s = RR_EN ? ~last_grant_r : 1'b0;
            end else begin
                winner_s = r1_valid;
            end
        end else begin
            grant_s  = 1'b0;
            winner_s = 1'b0;
        end
    end

    // Request handshake and shared ALU operand mux
    always_comb begin
        r0_ready = grant_s & ~winner_s;
        r1_ready = grant_s & winner_s;
        alu_a    = {DATA_W{1'b0}};
        alu_b    = {DATA_W{1'b0}};
        alu_c    = {OP_W{1'b0}};
        if (grant_s) begin
            if (winner_s) begin
                alu_a = r1_a;
                alu_b = r1_b;
                alu_c = r1_op;
            end else begin
                alu_a = r0_a;
                alu_b = r0_b;
                alu_c = r0_op;
            end
        end else begin
            alu_a = {DATA_W{1'b0}};
            alu_b = {DATA_W{1'b0}};
            alu_c = {OP_W{1'b0}};
        end
    end

    // Next-state: hold the result until its owner takes it; other rsp_ready is ignored
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RESP: begin
                if (owner_r ? r1_rsp_ready : r0_rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, ownership and captured result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            rsp_data_r   <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (grant_s) begin
                rsp_data_r   <= alu_y;
                owner_r      <= winner_s;
                last_grant_r <= winner_s;
            end
        end
    end

    assign r0_rsp_valid = (state_r == RESP) && !owner_r;
    assign r1_rsp_valid = (state_r == RESP) && owner_r;
    assign r0_rsp_data  = rsp_data_r;
    assign r1_rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed plus randomized bench for alu_share_arbiter (round-robin and fixed-priority instances)
// driving a behavioural ALU and checking against a transaction-level reference model.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready;
    logic [31:0] r0_a, r0_b, r0_rsp_data;
    logic [4:0]  r0_op;
    logic        r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready;
    logic [31:0] r1_a, r1_b, r1_rsp_data;
    logic [4:0]  r1_op;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [4:0]  alu_c;

    logic        fp_r0_valid, fp_r0_ready, fp_r0_rsp_valid, fp_r0_rsp_ready;
    logic [31:0] fp_r0_rsp_data;
    logic        fp_r1_valid, fp_r1_ready, fp_r1_rsp_valid, fp_r1_rsp_ready;
    logic [31:0] fp_r1_rsp_data;
    logic [31:0] fp_alu_a, fp_alu_b, fp_alu_y;
    logic [4:0]  fp_alu_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: 0 add, 1 sub, 2 signed less-than, 3 and, 4 or, 5 xor
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] op);
        case (op)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd3:    return a & b;
            5'd4:    return a | b;
            5'd5:    return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    always_comb alu_y    = alu_ref(alu_a, alu_b, alu_c);
    always_comb fp_alu_y = alu_ref(fp_alu_a, fp_alu_b, fp_alu_c);

    alu_share_arbiter #(.DATA_W(32), .OP_W(5), .RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_rsp_data(r0_rsp_data),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_rsp_data(r1_rsp_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_y(alu_y)
    );

    alu_share_arbiter #(.DATA_W(32), .OP_W(5), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .r0_valid(fp_r0_valid), .r0_ready(fp_r0_ready), .r0_a(32'd2), .r0_b(32'd3), .r0_op(5'd0),
        .r0_rsp_valid(fp_r0_rsp_valid), .r0_rsp_ready(fp_r0_rsp_ready), .r0_rsp_data(fp_r0_rsp_data),
        .r1_valid(fp_r1_valid), .r1_ready(fp_r1_ready), .r1_a(32'd8), .r1_b(32'd1), .r1_op(5'd1),
        .r1_rsp_valid(fp_r1_rsp_valid), .r1_rsp_ready(fp_r1_rsp_ready), .r1_rsp_data(fp_r1_rsp_data),
        .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_c(fp_alu_c), .alu_y(fp_alu_y)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: one outstanding result at most
    logic        pend;
    logic        who;
    logic [31:0] pend_val;
    logic        prio;
    logic        acc0, acc1, any, w, e0, e1;
    int          fp_grants;

    initial begin
        rst = 1'b1;
        r0_valid = 1'b1; r0_a = 32'd5; r0_b = 32'd7; r0_op = 5'd0; r0_rsp_ready = 1'b1;
        r1_valid = 1'b1; r1_a = 32'd9; r1_b = 32'd4; r1_op = 5'd1; r1_rsp_ready = 1'b1;
        fp_r0_valid = 1'b1; fp_r1_valid = 1'b1; fp_r0_rsp_ready = 1'b1; fp_r1_rsp_ready = 1'b1;

        // Reset held two cycles with both valid
        tick(); tick();
        chk("rst_r0_ready", 32'(r0_ready), 32'd0);
        chk("rst_r1_ready", 32'(r1_ready), 32'd0);
        chk("rst_r0_rsp_valid", 32'(r0_rsp_valid), 32'd0);
        chk("rst_r1_rsp_valid", 32'(r1_rsp_valid), 32'd0);
        chk("rst_r0_rsp_data", r0_rsp_data, 32'd0);
        chk("rst_r1_rsp_data", r1_rsp_data, 32'd0);

        // First tie after reset goes to requester 0: ADD 5+7
        rst = 1'b0; #1;
        chk("tie0_r0_ready", 32'(r0_ready), 32'd1);
        chk("tie0_r1_ready", 32'(r1_ready), 32'd0);
        chk("add_alu_a", alu_a, 32'd5);
        chk("add_alu_b", alu_b, 32'd7);
        chk("add_alu_c", 32'(alu_c), 32'd0);
        tick();
        chk("add_rsp_valid", 32'(r0_rsp_valid), 32'd1);
        chk("add_r1_rsp_valid", 32'(r1_rsp_valid), 32'd0);
        chk("add_rsp_data", r0_rsp_data, 32'd12);
        chk("resp_r0_ready", 32'(r0_ready), 32'd0);
        chk("resp_r1_ready", 32'(r1_ready), 32'd0);
        chk("resp_alu_a", alu_a, 32'd0);

        // Round robin: second grant to requester 1, SUB 9-4
        tick();
        chk("rr1_r1_ready", 32'(r1_ready), 32'd1);
        chk("rr1_r0_ready", 32'(r0_ready), 32'd0);
        chk("sub_alu_a", alu_a, 32'd9);
        chk("sub_alu_b", alu_b, 32'd4);
        chk("sub_alu_c", 32'(alu_c), 32'd1);
        tick();
        chk("sub_rsp_valid", 32'(r1_rsp_valid), 32'd1);
        chk("sub_r0_rsp_valid", 32'(r0_rsp_valid), 32'd0);
        chk("sub_rsp_data", r1_rsp_data, 32'd5);
        tick();
        chk("rr2_r0_ready", 32'(r0_ready), 32'd1);
        r1_a = 32'd3; r1_b = 32'd5; r1_op = 5'd1;
        tick();
        chk("rr2_rsp_data", r0_rsp_data, 32'd12);
        r1_rsp_ready = 1'b0;

        // Backpressure: requester 1 SUB 3-5 held while its rsp_ready is low
        tick();
        chk("rr3_r1_ready", 32'(r1_ready), 32'd1);
        chk("bp_alu_a", alu_a, 32'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_rsp_valid", 32'(r1_rsp_valid), 32'd1);
            chk("bp_rsp_data", r1_rsp_data, 32'hFFFF_FFFE);
            chk("bp_r0_rsp_valid", 32'(r0_rsp_valid), 32'd0);
            chk("bp_r0_ready", 32'(r0_ready), 32'd0);
            chk("bp_r1_ready", 32'(r1_ready), 32'd0);
        end

        // Reset in the middle of a held response
        rst = 1'b1;
        tick();
        chk("mid_rst_r1_rsp_valid", 32'(r1_rsp_valid), 32'd0);
        chk("mid_rst_r0_rsp_valid", 32'(r0_rsp_valid), 32'd0);
        chk("mid_rst_rsp_data", r1_rsp_data, 32'd0);
        rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0; r1_rsp_ready = 1'b1; #1;
        chk("idle_alu_a", alu_a, 32'd0);
        chk("idle_alu_b", alu_b, 32'd0);
        chk("idle_alu_c", 32'(alu_c), 32'd0);
        chk("idle_r0_ready", 32'(r0_ready), 32'd0);
        r1_valid = 1'b1; #1;
        chk("single_r1_ready", 32'(r1_ready), 32'd1);
        r0_valid = 1'b1; #1;
        chk("post_rst_tie_r0", 32'(r0_ready), 32'd1);
        chk("post_rst_tie_r1", 32'(r1_ready), 32'd0);

        // Signed compare: -1 < 1
        r1_valid = 1'b0; r0_a = 32'hFFFF_FFFF; r0_b = 32'd1; r0_op = 5'd2; #1;
        tick();
        chk("slt_rsp_valid", 32'(r0_rsp_valid), 32'd1);
        chk("slt_rsp_data", r0_rsp_data, 32'd1);
        r0_valid = 1'b0;
        tick();

        // Fixed priority instance: requester 1 never wins while requester 0 stays valid
        fp_grants = 0;
        for (int i = 0; i < 8; i++) begin
            chk("fp_r1_ready", 32'(fp_r1_ready), 32'd0);
            chk("fp_r1_rsp_valid", 32'(fp_r1_rsp_valid), 32'd0);
            if (fp_r0_ready) fp_grants++;
            tick();
        end
        chk("fp_r0_grants", 32'(fp_grants), 32'd4);

        // Randomized traffic against the transaction-level model
        rst = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0;
        tick();
        rst = 1'b0;
        pend = 1'b0; who = 1'b0; pend_val = 32'd0; prio = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!(r0_valid && !acc0)) begin
                r0_valid = ($urandom_range(0, 3) != 0);
                r0_a = $urandom; r0_b = $urandom; r0_op = 5'($urandom_range(0, 5));
            end else if ($urandom_range(0, 7) == 0) begin
                r0_valid = 1'b0;
            end
            if (!(r1_valid && !acc1)) begin
                r1_valid = ($urandom_range(0, 3) != 0);
                r1_a = $urandom; r1_b = $urandom; r1_op = 5'($urandom_range(0, 5));
            end else if ($urandom_range(0, 7) == 0) begin
                r1_valid = 1'b0;
            end
            r0_rsp_ready = ($urandom_range(0, 2) != 0);
            r1_rsp_ready = ($urandom_range(0, 2) != 0);
            #1;
            any = r0_valid | r1_valid;
            w   = (r0_valid && r1_valid) ? prio : r1_valid;
            e0  = !pend && any && !w;
            e1  = !pend && any && w;
            chk("rnd_r0_ready", 32'(r0_ready), 32'(e0));
            chk("rnd_r1_ready", 32'(r1_ready), 32'(e1));
            chk("rnd_r0_rsp_valid", 32'(r0_rsp_valid), 32'(pend && !who));
            chk("rnd_r1_rsp_valid", 32'(r1_rsp_valid), 32'(pend && who));
            if (pend) begin
                chk("rnd_rsp_data", who ? r1_rsp_data : r0_rsp_data, pend_val);
                chk("rnd_resp_alu_a", alu_a, 32'd0);
            end else if (any) begin
                chk("rnd_alu_a", alu_a, w ? r1_a : r0_a);
                chk("rnd_alu_b", alu_b, w ? r1_b : r0_b);
                chk("rnd_alu_c", 32'(alu_c), 32'(w ? r1_op : r0_op));
            end else begin
                chk("rnd_idle_alu_c", 32'(alu_c), 32'd0);
            end
            acc0 = e0;
            acc1 = e1;
            if (!pend && any) begin
                pend     = 1'b1;
                who      = w;
                pend_val = w ? alu_ref(r1_a, r1_b, r1_op) : alu_ref(r0_a, r0_b, r0_op);
                prio     = !w;
            end else if (pend && (who ? r1_rsp_ready : r0_rsp_ready)) begin
                pend = 1'b0;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
